vcve2_dmem_scheduler: RTL
=========================

# vcve2_dmem_scheduler

Round-robin scheduler that shares the single data-memory port of the vcve2 core between the vector register file (VRF) and the scalar LSU. Both requesters may be active at the same time. The block keeps the address phase stable until the grant arrives. It tracks up to `MaxOutstanding` issued transactions in an owner FIFO, so each `rvalid`/`err` returns to the requester that issued it. It sits between the VRF/LSU request ports and the core's `data_*` memory interface.

## Interface
- `MaxOutstanding`, default 2: maximum granted-but-unanswered transactions; legal range 1–8.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `data_req_o` / `data_we_o` / `data_be_o` / `data_addr_o` / `data_wdata_o`  out  1/1/4/32/32  memory address phase.
- `data_gnt_i` / `data_rvalid_i` / `data_err_i`  in  1/1/1  memory handshake and response.
- `data_rdata_i`  in  32  memory read data.
- `vrf_data_req_i` / `vrf_data_we_i` / `vrf_data_be_i` / `vrf_data_addr_i` / `vrf_data_wdata_i`  in  1/1/4/32/32  VRF request.
- `vrf_data_gnt_o` / `vrf_data_rvalid_o` / `vrf_data_err_o`  out  1/1/1  VRF handshake and response.
- `vrf_data_rdata_o`  out  32  VRF read data.
- `lsu_data_*`  same shape and directions as the `vrf_data_*` group  LSU port.
- `busy_o`  out  1  high while in HOLD or while the outstanding count is non-zero.
- `protocol_err_o`  out  1  sticky; set when `data_rvalid_i` arrives with nothing outstanding.

## Operation
- The owner FSM has two states:
  - IDLE: no address phase is pending. The owner is selected combinationally.
  - HOLD: a request was presented last cycle without a grant. The owner is locked.
- Owner selection in IDLE:
  - Only one requester high: that requester is the owner.
  - Both high: the owner is the opposite of `last_q`, the owner of the most recent grant.
  - `last_q` resets to LSU, so VRF wins the first contention.
- Transitions:
  - IDLE→HOLD when `data_req_o` is high and `data_gnt_i` is low.
  - HOLD→IDLE on the grant, or when the locked owner drops its request. Dropping a request is an OBI violation by the requester; the scheduler tolerates it and does not flag it.
- Address mux: all `data_*` outputs take the owner's fields. `data_req_o` equals `owner_req && !fifo_full && !rst_i`.
- Grant routing: `X_data_gnt_o = data_gnt_i && data_req_o && owner==X`. On a grant, push the owner into the FIFO and update `last_q`.
- Response routing:
  - `X_data_rvalid_o = data_rvalid_i && fifo_nonempty && head==X`.
  - `X_data_err_o = X_data_rvalid_o && data_err_i`.
  - Pop the FIFO on `data_rvalid_i` when it is non-empty.
  - `rdata` is broadcast to both requesters unqualified.
- Full FIFO: `data_req_o` is held low while `count==MaxOutstanding`, even if `data_rvalid_i` is high in the same cycle (no bypass). The FSM stays in its current state.
- Simultaneous push and pop: the count is unchanged and FIFO order is preserved.
- Stray `rvalid` with an empty FIFO: no requester sees `rvalid`, and `protocol_err_o` sets until reset.
- Reset mid-operation flushes the FIFO, FSM and `last_q`. Responses that arrive after reset are stray and set `protocol_err_o`.

## Timing
- Values while `rst_i` is asserted and in the first cycle after it:
  - FSM=IDLE, count=0, `last_q`=LSU.
  - `data_req_o`=0, `busy_o`=0, `protocol_err_o`=0, all `*_gnt_o`, `*_rvalid_o` and `*_err_o` = 0.
  - The remaining address outputs follow the LSU fields.
- Grant and response paths are combinational, with zero added latency. Arbitration adds no cycle.
- The earliest response is the cycle after the grant.
- Throughput is one grant per cycle, alternating between requesters under constant contention.
- The count is `$clog2(MaxOutstanding+1)` bits and never wraps: the push is blocked at full, and a pop at empty is ignored.
- FIFO pointers are `$clog2(MaxOutstanding)` bits (minimum 1) and wrap modulo `MaxOutstanding`.

## Structure
- `vcve2_dmem_pkg` holds the shared types:
  - `typedef enum logic {OWNER_LSU, OWNER_VRF} dmem_owner_e`.
  - `typedef enum logic {SCHED_IDLE, SCHED_HOLD} dmem_sched_state_e`.
- Sub-module `vcve2_dmem_owner_fifo`:
  - Parameterised depth, 1-bit entries.
  - Push/pop with simultaneous support.
  - Outputs `full_o`, `empty_o`, `head_o`, `count_o`.
  - Asynchronous active-high reset.
- The top level contains the FSM, `last_q`, the muxes and the sticky error flag.

## Test plan
- LSU only: request at A=0x100, `gnt` in the same cycle, `rvalid` next cycle with `rdata`=0xDEADBEEF. Expect `lsu_gnt` and `lsu_rvalid` high, VRF outputs low, `busy_o` high for exactly 1 cycle.
- Both requesting continuously, with `gnt` every cycle and `MaxOutstanding`=2 and `rvalid` every cycle. Expect the grant order VRF, LSU, VRF, LSU, and `rvalid`s routed in the same order.
- VRF requests and `gnt` is held low for 3 cycles while LSU asserts in cycle 2. Expect `data_addr_o` to stay the VRF address for all 4 cycles, then LSU to be granted on the next `gnt`.
- Two grants with no `rvalid` (`MaxOutstanding`=2). Expect `data_req_o`=0 while LSU is requesting. After `rvalid` (VRF with `err`=1), expect `vrf_data_err_o`=1 and `data_req_o` to re-assert the next cycle.
- `data_rvalid_i` with nothing outstanding. Expect no requester `rvalid` and `protocol_err_o`=1 until `rst_i` is asserted.
- Assert `rst_i` with one transaction outstanding. Expect all outputs 0, count=0, and a following `rvalid` to set `protocol_err_o`.

Source files
------------

// File: rtl/vcve2_dmem_pkg.sv
// Shared types for the data-memory scheduler: owner tags, FSM states and the address-phase bundle.
// Holds types only; it has no timing or flow-control behaviour of its own.
package vcve2_dmem_pkg;

   typedef enum logic {OWNER_LSU, OWNER_VRF} dmem_owner_e;

   typedef enum logic {SCHED_IDLE, SCHED_HOLD} dmem_sched_state_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   function automatic dmem_owner_e other_owner(input dmem_owner_e o);
      return (o == OWNER_VRF) ? OWNER_LSU : OWNER_VRF;
   endfunction

endpackage

// File: rtl/vcve2_dmem_owner_fifo.sv
// Owner-tag FIFO: records the requester of each issued transaction; push/pop take effect on the next edge.
// Flow control: a push while full and a pop while empty are both dropped, so the count never wraps.
module vcve2_dmem_owner_fifo
   import vcve2_dmem_pkg::*;
#(
   parameter int unsigned  Depth = 2,
   localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  dmem_owner_e     push_owner_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output dmem_owner_e     head_o,
   output logic [CntW-1:0] count_o
);

   dmem_owner_e     mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push;
   logic            do_pop;

   // Pointers wrap at Depth, which need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= OWNER_LSU;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_owner_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CntW'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

endmodule

// File: rtl/vcve2_dmem_scheduler.sv
// Round-robin arbiter sharing the data-memory port between VRF and LSU; grant/response paths add zero cycles.
// Backpressure: a stalled address phase is locked to its owner, and new requests stall while MaxOutstanding are in flight.
module vcve2_dmem_scheduler
   import vcve2_dmem_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,

   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [31:0] data_rdata_i,

   input  logic        vrf_data_req_i,
   input  logic        vrf_data_we_i,
   input  logic [3:0]  vrf_data_be_i,
   input  logic [31:0] vrf_data_addr_i,
   input  logic [31:0] vrf_data_wdata_i,
   output logic        vrf_data_gnt_o,
   output logic        vrf_data_rvalid_o,
   output logic        vrf_data_err_o,
   output logic [31:0] vrf_data_rdata_o,

   input  logic        lsu_data_req_i,
   input  logic        lsu_data_we_i,
   input  logic [3:0]  lsu_data_be_i,
   input  logic [31:0] lsu_data_addr_i,
   input  logic [31:0] lsu_data_wdata_i,
   output logic        lsu_data_gnt_o,
   output logic        lsu_data_rvalid_o,
   output logic        lsu_data_err_o,
   output logic [31:0] lsu_data_rdata_o,

   output logic        busy_o,
   output logic        protocol_err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   dmem_sched_state_e state_q;
   dmem_sched_state_e state_d;
   dmem_owner_e       last_q;
   dmem_owner_e       hold_owner_q;
   dmem_owner_e       owner;
   dmem_owner_e       head;
   dmem_req_t         vrf_fields;
   dmem_req_t         lsu_fields;
   dmem_req_t         sel_fields;
   logic              owner_req;
   logic              grant;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CntW-1:0]   fifo_count;
   logic              perr_q;
   logic              resp_vld;

   assign vrf_fields = '{we: vrf_data_we_i, be: vrf_data_be_i,
                         addr: vrf_data_addr_i, wdata: vrf_data_wdata_i};
   assign lsu_fields = '{we: lsu_data_we_i, be: lsu_data_be_i,
                         addr: lsu_data_addr_i, wdata: lsu_data_wdata_i};

   // Idle requesters and reset both park the mux on the LSU fields.
   always_comb begin
      owner = OWNER_LSU;
      if (rst_i) begin
         owner = OWNER_LSU;
      end else if (state_q == SCHED_HOLD) begin
         owner = hold_owner_q;
      end else if (vrf_data_req_i && lsu_data_req_i) begin
         owner = other_owner(last_q);
      end else if (vrf_data_req_i) begin
         owner = OWNER_VRF;
      end
   end

   assign owner_req  = (owner == OWNER_VRF) ? vrf_data_req_i : lsu_data_req_i;
   assign sel_fields = (owner == OWNER_VRF) ? vrf_fields : lsu_fields;

   assign data_req_o   = owner_req && !fifo_full && !rst_i;
   assign data_we_o    = sel_fields.we;
   assign data_be_o    = sel_fields.be;
   assign data_addr_o  = sel_fields.addr;
   assign data_wdata_o = sel_fields.wdata;

   assign grant          = data_gnt_i && data_req_o;
   assign vrf_data_gnt_o = grant && (owner == OWNER_VRF);
   assign lsu_data_gnt_o = grant && (owner == OWNER_LSU);

   assign resp_vld          = data_rvalid_i && !fifo_empty;
   assign vrf_data_rvalid_o = resp_vld && (head == OWNER_VRF);
   assign lsu_data_rvalid_o = resp_vld && (head == OWNER_LSU);
   assign vrf_data_err_o    = vrf_data_rvalid_o && data_err_i;
   assign lsu_data_err_o    = lsu_data_rvalid_o && data_err_i;
   assign vrf_data_rdata_o  = data_rdata_i;
   assign lsu_data_rdata_o  = data_rdata_i;

   assign busy_o         = (state_q == SCHED_HOLD) || (fifo_count != '0);
   assign protocol_err_o = perr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCHED_IDLE: if (data_req_o && !data_gnt_i) state_d = SCHED_HOLD;
         // A requester withdrawing mid-phase is tolerated silently.
         SCHED_HOLD: if (grant || !owner_req) state_d = SCHED_IDLE;
         default:    state_d = SCHED_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= SCHED_IDLE;
         last_q       <= OWNER_LSU;
         hold_owner_q <= OWNER_LSU;
         perr_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == SCHED_HOLD) begin
            hold_owner_q <= owner;
         end
         if (grant) begin
            last_q <= owner;
         end
         if (data_rvalid_i && fifo_empty) begin
            perr_q <= 1'b1;
         end
      end
   end

   vcve2_dmem_owner_fifo #(
      .Depth(MaxOutstanding)
   ) u_owner_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (grant),
      .push_owner_i(owner),
      .pop_i       (data_rvalid_i),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head),
      .count_o     (fifo_count)
   );

endmodule
